// File: rtl/store_buffer_pkg.sv
// Purpose: shared definitions for the committed-store buffer.
//   Default widths, word-offset/byte-mask helpers and the entry layout
//   {addr_word, data, mask}.
// Ports: none (package).
package sb_defs;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned MASK_W     = DATA_W_DEF / 8;
  localparam int unsigned WORD_OFF   = $clog2(MASK_W);

  // Entry layout at default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-WORD_OFF-1:0] addr_word;
    logic [DATA_W_DEF-1:0]          data;
    logic [MASK_W-1:0]              mask;
  } sb_entry_t;

  // Byte-enable width for a given data width.
  function automatic int unsigned sb_mask_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits dropped to form a word address.
  function automatic int unsigned sb_word_off(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Purpose: per-entry forwarding comparator.
// Ports:
//   valid       in  entry holds a pending store
//   entry_word  in  entry word address
//   load_word   in  load word address
//   entry_mask  in  entry byte enables
//   load_mask   in  bytes requested by the load
//   match_c     out entry is valid and word addresses are equal
//   cover_c     out entry mask covers every requested byte
module store_buffer_match #(
  parameter int unsigned AW = 30,
  parameter int unsigned MW = 4
) (
  input  logic          valid,
  input  logic [AW-1:0] entry_word,
  input  logic [AW-1:0] load_word,
  input  logic [MW-1:0] entry_mask,
  input  logic [MW-1:0] load_mask,
  output logic          match_c,
  output logic          cover_c
);

  assign match_c = valid && (entry_word == load_word);
  assign cover_c = ((entry_mask & load_mask) == load_mask);

endmodule

// File: rtl/store_buffer.sv
// Purpose: in-order committed-store FIFO between MEM and data memory,
//   draining one entry per memory acknowledge, with zero-latency
//   store-to-load forwarding from the youngest matching entry.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   st_valid/st_addr/st_data/st_mask store push; st_ready = not full
//   ld_valid/ld_addr/ld_mask         load lookup
//   ld_hit/ld_data/ld_stall          forwarding result (combinational)
//   mem_wr_en/addr/data/mask         head entry presented to memory
//   mem_wr_ack                       memory accepted the head
//   count, empty                     occupancy
module store_buffer
  import sb_defs::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [DATA_W/8-1:0]        st_mask,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W/8-1:0]        ld_mask,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_stall,
  output logic                       mem_wr_en,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [DATA_W-1:0]          mem_wr_data,
  output logic [DATA_W/8-1:0]        mem_wr_mask,
  input  logic                       mem_wr_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned MW    = sb_mask_w(DATA_W);
  localparam int unsigned WO    = sb_word_off(DATA_W);
  localparam int unsigned AWW   = ADDR_W - WO;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [AWW-1:0]    r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [MW-1:0]     r_mask [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_match;
  logic [DEPTH-1:0]  w_cover;
  logic              w_found;
  logic [PTR_W-1:0]  w_sel;
  logic [PTR_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_byte_en;
  logic              w_unused_lo;

  // Byte-offset bits never participate in matching or storage.
  assign w_unused_lo = ^{st_addr[WO-1:0], ld_addr[WO-1:0]};

  assign st_ready  = (r_count != CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign mem_wr_en = !empty;
  assign w_push    = st_valid && st_ready;
  assign w_pop     = mem_wr_ack && mem_wr_en;

  assign mem_wr_addr = {r_addr[r_rd_ptr], {WO{1'b0}}};
  assign mem_wr_data = r_data[r_rd_ptr];
  assign mem_wr_mask = r_mask[r_rd_ptr];

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      // Push and pop never target the same slot: push needs not-full,
      // pop needs not-empty, and the pointers only coincide at those limits.
      if (w_push) begin
        r_addr[r_wr_ptr]  <= st_addr[ADDR_W-1:WO];
        r_data[r_wr_ptr]  <= st_data;
        r_mask[r_wr_ptr]  <= st_mask;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    store_buffer_match #(.AW(AWW), .MW(MW)) u_match (
      .valid      (r_valid[g]),
      .entry_word (r_addr[g]),
      .load_word  (ld_addr[ADDR_W-1:WO]),
      .entry_mask (r_mask[g]),
      .load_mask  (ld_mask),
      .match_c    (w_match[g]),
      .cover_c    (w_cover[g])
    );
  end

  // Walk from oldest (rd_ptr) to youngest; the last match seen wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (w_match[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Expand the selected entry's byte enables to a bit mask.
  always_comb begin
    w_byte_en = '0;
    for (int b = 0; b < MW; b++) begin
      w_byte_en[b*8 +: 8] = {8{r_mask[w_sel][b]}};
    end
  end

  assign ld_hit   = ld_valid && w_found && w_cover[w_sel];
  assign ld_stall = ld_valid && w_found && !w_cover[w_sel];
  assign ld_data  = ld_hit ? (r_data[w_sel] & w_byte_en) : '0;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Committed-store buffer between the MEM stage and data memory. Queues in-order stores from the pipeline and drains them to memory one per acknowledge.
- Provides store-to-load forwarding, the opposite direction to the existing load-to-store forward path. A load whose word address matches a pending store receives the youngest store's data in the same cycle.
- If that store does not cover every requested byte, the load is stalled.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byte mask width is DATA_W/8.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store push request from MEM stage.
- st_addr  in  ADDR_W  store byte address; low log2(DATA_W/8) bits are ignored.
- st_data  in  DATA_W  store data, already lane-aligned.
- st_mask  in  DATA_W/8  byte enables; must be nonzero.
- st_ready  out  1  buffer can accept a store (not full).
- ld_valid  in  1  load lookup request.
- ld_addr  in  ADDR_W  load byte address.
- ld_mask  in  DATA_W/8  bytes the load needs.
- ld_hit  out  1  the youngest matching entry fully covers ld_mask; ld_data is valid.
- ld_data  out  DATA_W  forwarded data; bytes outside the entry mask are 0.
- ld_stall  out  1  a matching entry exists but does not cover ld_mask.
- mem_wr_en  out  1  head entry is presented to memory.
- mem_wr_addr  out  ADDR_W  head word address, low bits zero.
- mem_wr_data  out  DATA_W  head data.
- mem_wr_mask  out  DATA_W/8  head byte enables.
- mem_wr_ack  in  1  memory accepted the head this cycle.
- count  out  clog2(DEPTH+1)  number of valid entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, rst_n=0):
  - all entries invalid; head and tail pointers 0; count 0.
  - mem_wr_en=0, st_ready=1, ld_hit=0, ld_stall=0, ld_data=0, empty=1.
- Storage: circular FIFO indexed by wr_ptr and rd_ptr, each clog2(DEPTH) bits.
  - Pointers wrap DEPTH-1 -> 0.
  - Full/empty are decided from count, not from pointer equality.
- Push: st_valid && st_ready writes the entry at wr_ptr on the rising edge.
  - wr_ptr increments; count increments unless a pop happens in the same cycle.
- st_ready = (count != DEPTH).
  - No same-cycle pop bypass: when full, a push is refused even if mem_wr_ack=1.
  - st_valid while !st_ready is dropped; the pipeline must stall upstream.
- Drain:
  - mem_wr_en = !empty; mem_wr_addr, mem_wr_data and mem_wr_mask come from the entry at rd_ptr (combinational).
  - mem_wr_ack && mem_wr_en pops: rd_ptr increments and count decrements.
  - mem_wr_ack while empty is ignored.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Forwarding (combinational, zero latency):
  - Compare ld_addr[ADDR_W-1:2] against every valid entry's word address.
  - Select the youngest match by age order from rd_ptr, not by index.
  - If ld_valid=0 or no entry matches: ld_hit=0, ld_stall=0, ld_data=0.
  - If the youngest match has (mask & ld_mask) == ld_mask: ld_hit=1, and ld_data carries the entry data masked by the entry mask.
  - Otherwise ld_stall=1 and ld_hit=0. Older matching entries are never merged.
- Same-cycle visibility:
  - A store being pushed this cycle is not visible to a load this cycle; it is visible from the next cycle.
  - An entry being popped this cycle still forwards this cycle.
- ld_hit and ld_stall are mutually exclusive.
- Reset asserted mid-drain discards all pending stores. Memory sees mem_wr_en drop asynchronously.

Decomposition:
- Shared package/include sb_defs holds:
  - localparams WORD_OFF = clog2(DATA_W/8) and MASK_W = DATA_W/8;
  - the entry field layout {addr_word, data, mask}.
- One natural sub-module: store_buffer_match, the per-entry comparator. It takes valid, entry word address, load word address, entry mask and ld_mask, and outputs match and cover. It is instantiated DEPTH times; the youngest-select priority logic stays in the top level.

Test Plan:
- Push 0x100/0xDEADBEEF/mask 0xF, then next cycle load 0x100 mask 0xF -> ld_hit=1, ld_data=0xDEADBEEF, ld_stall=0.
- Push 0x100/0x11111111 then 0x100/0x22222222 (both mask 0xF), no ack; load 0x102 mask 0x4 -> ld_hit=1, ld_data=0x22222222 (youngest wins).
- Push 0x200/0x000000AA/mask 0x1; load 0x200 mask 0xF -> ld_stall=1, ld_hit=0. Load 0x204 -> both 0.
- Push 4 stores with no ack -> count=4, st_ready=0. Fifth push with ack=1 is refused and count=3 next cycle. Then a push with ack=1 keeps count=3, and pointers wrap.
- Hold mem_wr_ack=1 -> entries drain in order, one per cycle, matching push order; mem_wr_en=0 and empty=1 after the last.
- With 2 entries pending, pulse rst_n low mid-cycle -> mem_wr_en and count drop immediately; after release, a load to the old address -> ld_hit=0.
